mux_arb: RTL

- Parametrised, registered N-channel, W-bit stream multiplexer with valid/ready handshakes on every input and on the output.
- Two selection modes:
  - fixed: external sel picks the channel, the same selection as the existing registered 4:1 mux.
  - round-robin: the block arbitrates among valid channels.
- Sits between multiple producer streams and a single consumer; the one-deep output register gives a registered output and 1-cycle latency.

---
 rtl/mux_arb_if.sv | 26 ++
 rtl/mux_arb.sv | 89 ++++++++
 2 files changed

// File: rtl/mux_arb_if.sv
// Stream bundle for mux_arb: NCH producer channels in, one registered consumer stream out.
interface mux_arb_if #(
    parameter int NCH  = 4,
    parameter int W    = 1,
    parameter int SELW = 2
);
    logic [NCH*W-1:0] in_data;
    logic [NCH-1:0]   in_valid;
    logic [NCH-1:0]   in_ready;
    logic             mode;
    logic [SELW-1:0]  sel;
    logic [W-1:0]     out_data;
    logic [SELW-1:0]  out_ch;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/mux_arb.sv
// Registered N-channel stream mux with fixed-select or round-robin arbitration
// feeding a one-deep output register (1-cycle latency, full throughput).
module mux_arb #(
    parameter int NCH  = 4,
    parameter int W    = 1,
    parameter int SELW = 2
) (
    input logic       clk,
    input logic       rst,
    mux_arb_if.slave  bus
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state, state_nxt;
    logic [W-1:0]     data_q;
    logic [SELW-1:0]  ch_q;
    logic [SELW-1:0]  last;
    logic             load;
    logic             granted;
    logic [SELW-1:0]  g;
    logic [NCH-1:0]   vsh;
    logic [NCH*W-1:0] dsh;
    int unsigned      idx;

    assign load = (state == EMPTY) || bus.out_ready;

    // Round-robin scans last+1 .. last+NCH so the previously served channel is tried last.
    always_comb begin
        granted = 1'b0;
        g       = '0;
        vsh     = '0;
        idx     = 0;
        if (bus.mode == 1'b0) begin
            vsh = bus.in_valid >> bus.sel;
            if ((32'(bus.sel) < NCH) && vsh[0]) begin
                granted = 1'b1;
                g       = bus.sel;
            end
        end else begin
            for (int unsigned k = 1; k <= NCH; k++) begin
                idx = (32'(last) + k) % NCH;
                vsh = bus.in_valid >> idx;
                if (!granted && vsh[0]) begin
                    granted = 1'b1;
                    g       = SELW'(idx);
                end
            end
        end
    end

    always_comb begin
        bus.in_ready = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            bus.in_ready[c] = load && granted && !rst && (32'(g) == c);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (granted) state_nxt = FULL;
            FULL:    if (bus.out_ready && !granted) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    assign dsh = bus.in_data >> (32'(g) * W);

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            ch_q   <= '0;
            last   <= SELW'(NCH - 1);
        end else if (granted && load) begin
            data_q <= dsh[W-1:0];
            ch_q   <= g;
            last   <= g;
        end
    end

    assign bus.out_valid = (state == FULL);
    assign bus.out_data  = data_q;
    assign bus.out_ch    = ch_q;
endmodule
